// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a DMA requester, CPU priority.
// Define ARB_STATS_EN to build the saturating forced-conflict counter.
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [15:0] conflict_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] FORCE = 2'd2;
    localparam logic [8:0] LIMIT = 9'(MAX_WAIT);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] cnt_nxt;
    logic [8:0] cnt_inc;
    logic       cpu_dm;

    assign cpu_dm    = (cpu_rd | cpu_wr) & ~cpu_addr[30];
    assign dma_gnt   = dma_req & ((state == FORCE) | ~cpu_dm);
    assign cpu_stall = cpu_dm & dma_gnt;

    assign mem_rd    = dma_gnt ? ~dma_wr : (cpu_dm & cpu_rd);
    assign mem_wr    = dma_gnt ? dma_wr : (cpu_dm & cpu_wr);
    assign mem_addr  = dma_gnt ? dma_addr : cpu_addr;
    assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;

    assign cnt_inc = {1'b0, wait_cnt} + 9'd1;

    // wait_cnt holds the blocked cycles seen so far; the compare looks one
    // cycle ahead so the forced grant lands in cycle index MAX_WAIT.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = wait_cnt;
        case (state)
            IDLE: begin
                if (dma_req & ~dma_gnt) begin
                    cnt_nxt   = 8'd1;
                    state_nxt = (LIMIT == 9'd1) ? FORCE : WAIT;
                end else begin
                    cnt_nxt = 8'd0;
                end
            end
            WAIT: begin
                if (~dma_req | dma_gnt) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else if (cnt_inc == LIMIT) begin
                    state_nxt = FORCE;
                    cnt_nxt   = cnt_inc[7:0];
                end else begin
                    cnt_nxt = cnt_inc[7:0];
                end
            end
            FORCE: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_rdata  <= 32'd0;
            dma_rvalid <= 1'b0;
        end else if (dma_gnt & ~dma_wr) begin
            dma_rdata  <= mem_rdata;
            dma_rvalid <= 1'b1;
        end else begin
            dma_rvalid <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_q <= 16'd0;
        end else if (cpu_stall && stat_q != 16'hFFFF) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign conflict_cnt = stat_q;
`else
    assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner
// sequences and randomized traffic against a blocked-cycle reference model.
module tb_dmem_arbiter;

    localparam int MW = 8;
`ifdef ARB_STATS_EN
    localparam logic [31:0] EXP_CONF3 = 32'd3;
`else
    localparam logic [31:0] EXP_CONF3 = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall;
    logic        dma_req, dma_wr;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] conflict_cnt;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .dma_rvalid(dma_rvalid),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // reference model: blocked cycles of the current request, registered outputs
    int          blocked;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    int          e_conf;
    logic        pend;
    int          n_blocked;
    logic        n_rvalid;
    logic [31:0] n_rdata;
    int          n_conf;
    logic        pw;
    logic [7:0]  pw_idx;
    logic [31:0] pw_data;
    logic        m_gnt;

    task automatic idle_inputs();
        cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_wr = 0; dma_addr = 0; dma_wdata = 0;
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        idle_inputs();
        blocked = 0; e_rvalid = 0; e_rdata = 0; e_conf = 0; pend = 0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic cyc(input logic crd, input logic cwr,
                       input logic [31:0] caddr, input logic [31:0] cwd,
                       input logic dq, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
        logic cdm, g, st, erd, ewr;
        logic [31:0] ea, ewd;
        if (pend) begin
            @(posedge clk);
            #1;
            blocked = n_blocked; e_rvalid = n_rvalid;
            e_rdata = n_rdata; e_conf = n_conf;
            if (pw) ref_mem[pw_idx] = pw_data;
        end
        cpu_rd = crd; cpu_wr = cwr; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = dq; dma_wr = dw; dma_addr = da; dma_wdata = dd;
        #4;
        cdm = (crd | cwr) & ~caddr[30];
        g   = dq & (~cdm | (blocked >= MW));
        st  = g & cdm;
        if (g) begin
            erd = ~dw; ewr = dw; ea = da; ewd = dd;
        end else begin
            erd = cdm & crd; ewr = cdm & cwr; ea = caddr; ewd = cwd;
        end
        chk("dma_gnt", {31'd0, dma_gnt}, {31'd0, g});
        chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, st});
        chk("mem_rd", {31'd0, mem_rd}, {31'd0, erd});
        chk("mem_wr", {31'd0, mem_wr}, {31'd0, ewr});
        if (erd | ewr) chk("mem_addr", mem_addr, ea);
        if (ewr) chk("mem_wdata", mem_wdata, ewd);
        chk("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, e_rvalid});
        chk("dma_rdata", dma_rdata, e_rdata);
        chk("conflict_cnt", {16'd0, conflict_cnt}, 32'(e_conf));
        n_blocked = (dq & ~g) ? blocked + 1 : 0;
        n_rvalid  = g & ~dw;
        n_rdata   = (g & ~dw) ? ref_mem[da[9:2]] : e_rdata;
`ifdef ARB_STATS_EN
        n_conf = (st && e_conf < 65535) ? e_conf + 1 : e_conf;
`else
        n_conf = 0;
`endif
        pw = ewr; pw_idx = ea[9:2]; pw_data = ewd;
        m_gnt = g;
        pend = 1'b1;
    endtask

    // contended DMA read of 0x20 against a CPU load from 0x0
    task automatic contend(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
            chk(nm, {31'd0, dma_gnt}, {31'd0, (i == MW)});
        end
    endtask

    typedef struct {
        logic        crd, cwr;
        logic [31:0] caddr;
        logic        dreq, dwr;
        logic [31:0] daddr;
        logic        gnt, stall, mrd, mwr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic        dh, dq, dw, crd, cwr;
        logic [31:0] da, dd;
        int          op;

        tbl[0] = '{0, 0, 32'h0,        1, 1, 32'h10, 1, 0, 0, 1};
        tbl[1] = '{1, 0, 32'h0,        1, 0, 32'h20, 0, 0, 1, 0};
        tbl[2] = '{1, 0, 32'h40000010, 1, 0, 32'h20, 1, 0, 1, 0};
        tbl[3] = '{0, 1, 32'h4,        1, 1, 32'h8,  0, 0, 0, 1};
        tbl[4] = '{0, 1, 32'h40000000, 0, 0, 32'h0,  0, 0, 0, 0};
        tbl[5] = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0};
        tbl[6] = '{1, 0, 32'h100,      0, 1, 32'h30, 0, 0, 1, 0};
        tbl[7] = '{0, 1, 32'h40000020, 1, 0, 32'h24, 1, 0, 1, 0};

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem[8] = 32'h1234;
        ref_mem[8] = 32'h1234;

        reset = 1'b1;
        idle_inputs();
        #2;
        rst_pulse();
        chk("reset_rvalid", {31'd0, dma_rvalid}, 32'd0);
        chk("reset_rdata", dma_rdata, 32'd0);
        chk("reset_conf", {16'd0, conflict_cnt}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].crd, tbl[i].cwr, tbl[i].caddr, 32'h0,
                tbl[i].dreq, tbl[i].dwr, tbl[i].daddr, 32'hDEAD_0000);
            chk("tbl_gnt", {31'd0, dma_gnt}, {31'd0, tbl[i].gnt});
            chk("tbl_stall", {31'd0, cpu_stall}, {31'd0, tbl[i].stall});
            chk("tbl_mrd", {31'd0, mem_rd}, {31'd0, tbl[i].mrd});
            chk("tbl_mwr", {31'd0, mem_wr}, {31'd0, tbl[i].mwr});
            rst_pulse();
        end

        cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hA5A5A5A5);
        chk("t1_gnt", {31'd0, dma_gnt}, 32'd1);
        chk("t1_mwr", {31'd0, mem_wr}, 32'd1);
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("t1_mem", mem[4], 32'hA5A5A5A5);

        rst_pulse();
        contend(MW + 1, "t2_gnt");
        chk("t2_stall", {31'd0, cpu_stall}, 32'd1);
        cyc(1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("t2_rvalid", {31'd0, dma_rvalid}, 32'd1);
        chk("t2_rdata", dma_rdata, 32'h1234);

        rst_pulse();
        cyc(1, 0, 32'h40000010, 32'h0, 1, 0, 32'h20, 32'h0);
        chk("t3_gnt", {31'd0, dma_gnt}, 32'd1);
        chk("t3_stall", {31'd0, cpu_stall}, 32'd0);

        rst_pulse();
        contend(6, "t4_pre");
        rst_pulse();
        chk("t4_rvalid", {31'd0, dma_rvalid}, 32'd0);
        contend(MW + 1, "t4_gnt");

        rst_pulse();
        contend(4, "t5_pre");
        cyc(1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("t5_drop", {31'd0, dma_gnt}, 32'd0);
        contend(MW + 1, "t5_gnt");

        rst_pulse();
        for (int k = 0; k < 3; k++) begin
            contend(MW + 1, "t6_gnt");
            cyc(1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        end
        chk("t6_conf", {16'd0, conflict_cnt}, EXP_CONF3);

        rst_pulse();
        dh = 0; dq = 0; dw = 0; da = 0; dd = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!dh) begin
                dq = 1'($urandom_range(0, 1));
                dw = 1'($urandom_range(0, 1));
                da = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                dd = $urandom;
            end
            op  = int'($urandom_range(0, 3));
            crd = (op == 1) || (op == 3);
            cwr = (op == 2);
            cyc(crd, cwr,
                {1'b0, 1'($urandom_range(0, 3) == 0), 20'd0,
                 8'($urandom_range(0, 255)), 2'b00},
                $urandom, dq, dw, da, dd);
            dh = dq & ~m_gnt;
        end
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
